glitch_filter_edge_det: RTL and testbench
=========================================

Name: glitch_filter_edge_det

Overview:
- Downstream consumer of the 1-bit delay-line stage.
- Qualifies the delayed bit: a new level is accepted only after it holds for STABLE_CNT consecutive clock samples.
- Emits one-cycle rise/fall pulses and keeps a saturating count of qualified edges.
- Feeds control logic that needs a glitch-free level plus edge strobes.

Parameters:
- STABLE_CNT, 4, consecutive samples required to accept a new level; legal range 2..255.
- CNT_W, 8, width of the qualified-edge counter.
- TMR_W, $clog2(STABLE_CNT)+1, width of the internal stability timer; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- en  in  1  filter enable; 0 freezes qualification.
- in  in  1  delayed bit from the delay-line stage; already registered, sampled directly.
- cnt_clr  in  1  synchronous clear of edge_cnt.
- level  out  1  filtered level, registered.
- rise  out  1  one-cycle pulse on a qualified 0->1 transition, registered.
- fall  out  1  one-cycle pulse on a qualified 1->0 transition, registered.
- edge_cnt  out  CNT_W  saturating count of qualified edges (rise+fall).
- busy  out  1  1 while a candidate transition is being checked (state CHK_*); combinational from state.

Behaviour:
- Reset (rstn=0 at clk edge):
  - state=LOW_STB, timer=0.
  - level=0, rise=0, fall=0, edge_cnt=0, busy=0.
  - Reset overrides all other inputs, including mid-check; a pending candidate is discarded.
- States: LOW_STB, CHK_HIGH, HIGH_STB, CHK_LOW.
- LOW_STB:
  - en=1 and in=1: go to CHK_HIGH, timer=1.
  - Otherwise stay.
- CHK_HIGH:
  - in=0: return to LOW_STB, timer=0 (glitch rejected, no pulse).
  - Else if timer==STABLE_CNT-1: go to HIGH_STB; level<=1, rise<=1, timer=0.
  - Else timer<=timer+1.
- HIGH_STB / CHK_LOW: mirror images of LOW_STB / CHK_HIGH, with in=0 as the candidate; on acceptance level<=0, fall<=1.
- Latency:
  - in sampled at the new value on edges k..k+STABLE_CNT-1 means level/rise update at edge k+STABLE_CNT-1.
  - Visible from the following cycle, i.e. STABLE_CNT-1 cycles after the first qualifying sample.
- rise/fall:
  - Default 0 every cycle; asserted for exactly one cycle.
  - Never both 1 in the same cycle.
- en=0:
  - CHK_HIGH returns to LOW_STB and CHK_LOW returns to HIGH_STB, timer=0.
  - Stable states hold; no pulses; level holds.
  - edge_cnt still responds to cnt_clr.
- edge_cnt:
  - Increments by 1 in the cycle rise or fall is generated (same edge that sets the pulse).
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 forces 0 and wins over a simultaneous increment.
- No combinational path from in to any output; busy is the only output decoded directly from state.

Decomposition:
- Package glitch_filter_pkg:
  - state enum typedef (LOW_STB, CHK_HIGH, HIGH_STB, CHK_LOW; 2-bit encoding).
  - localparam MIN_STABLE_CNT=2.
- Elaboration-time check: STABLE_CNT >= MIN_STABLE_CNT.
- One sub-module, sat_counter:
  - Parameter W.
  - Ports clk, rstn, clr, inc, q.
  - Clear-priority saturating up-counter, instantiated for edge_cnt.

Test Plan:
- Reset with in=1, en=1 -> level=0, edge_cnt=0, busy=0; after release, in held 1 for 4 cycles -> rise=1 for exactly one cycle 3 cycles after the first high sample, level=1, edge_cnt=1.
- Glitch: from LOW_STB, in=1 for 3 cycles then 0 (STABLE_CNT=4) -> no rise, level stays 0, busy high 3 cycles then 0, edge_cnt unchanged.
- Full cycle: rise accepted, then in=0 held 4 cycles -> fall=1 for one cycle, level=0, edge_cnt=2.
- Saturation with CNT_W=2: 5 qualified edges -> edge_cnt 1,2,3,3,3; then cnt_clr asserted on the same cycle as a 6th qualified edge -> edge_cnt=0 and rise/fall still pulses.
- en dropped mid-check (in=1, en=0 on 2nd CHK_HIGH cycle) -> returns to LOW_STB, busy=0, no rise; en=1 again with in=1 -> full 4-sample requalification needed.
- rstn=0 during CHK_LOW -> next cycle level=0, state LOW_STB, fall=0, edge_cnt=0.

Source files
------------

// File: rtl/glitch_filter_pkg.sv
// Shared types and limits for the glitch filter / edge detector.
// The state encoding is 2 bits, so busy can be decoded straight from the register.
package glitch_filter_pkg;

  localparam int MIN_STABLE_CNT = 2;

  typedef enum logic [1:0] {
    LOW_STB  = 2'b00,
    CHK_HIGH = 2'b01,
    HIGH_STB = 2'b10,
    CHK_LOW  = 2'b11
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a clear that has priority over increment.
// One cycle from inc/clr to q; holds at all-ones and never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/glitch_filter_edge_det.sv
// Accepts a new level on in only after STABLE_CNT consecutive samples, then pulses rise/fall.
// Level/pulses update on the STABLE_CNT-th qualifying edge; no flow control, en=0 aborts checks.
module glitch_filter_edge_det
  import glitch_filter_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             in,
  input  logic             cnt_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             busy
);

  localparam int TMR_W = $clog2(STABLE_CNT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STABLE_CNT - 1);

  if (STABLE_CNT < MIN_STABLE_CNT || STABLE_CNT > 255) begin : g_bad_stable_cnt
    $error("glitch_filter_edge_det: STABLE_CNT out of range 2..255");
  end

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= LOW_STB;
      timer_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The sample that opens a check counts as the first of STABLE_CNT.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW_STB: begin
        if (en && in) begin
          state_d = CHK_HIGH;
          timer_d = TMR_W'(1);
        end
      end
      CHK_HIGH: begin
        if (!en || !in) begin
          state_d = LOW_STB;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = HIGH_STB;
          level_d = 1'b1;
          rise_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HIGH_STB: begin
        if (en && !in) begin
          state_d = CHK_LOW;
          timer_d = TMR_W'(1);
        end
      end
      CHK_LOW: begin
        if (!en || in) begin
          state_d = HIGH_STB;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = LOW_STB;
          level_d = 1'b0;
          fall_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = LOW_STB;
        timer_d = '0;
      end
    endcase
  end

  // Counts on the same edge that registers the pulse.
  sat_counter #(
    .W (CNT_W)
  ) u_edge_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .inc  (rise_d | fall_d),
    .q    (edge_cnt)
  );

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = (state_q == CHK_HIGH) || (state_q == CHK_LOW);

endmodule

// File: tb/tb_glitch_filter_edge_det.sv
// Directed bench for glitch_filter_edge_det with STABLE_CNT=4 and a 2-bit edge counter.
module tb_glitch_filter_edge_det;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       in;
  logic       cnt_clr;
  logic       level;
  logic       rise;
  logic       fall;
  logic [1:0] edge_cnt;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  glitch_filter_edge_det #(
    .STABLE_CNT (4),
    .CNT_W      (2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .in       (in),
    .cnt_clr  (cnt_clr),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .edge_cnt (edge_cnt),
    .busy     (busy)
  );

  // Advance one clock; outputs are read 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    in = v;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; in = 1'b1; cnt_clr = 1'b0;
    step(); step();
    vectors++; if (level !== 1'b0) begin miscompares++; $display("FAIL reset_level: got %b want 0", level); end
    vectors++; if (edge_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", edge_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL reset_rise: got %b want 0", rise); end
    rstn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++; if (rise !== (i == 4)) begin miscompares++; $display("FAIL first_rise[%0d]: got %b want %b", i, rise, (i == 4)); end
      vectors++; if (busy !== (i < 4)) begin miscompares++; $display("FAIL first_busy[%0d]: got %b want %b", i, busy, (i < 4)); end
    end
    vectors++; if (level !== 1'b1) begin miscompares++; $display("FAIL first_level: got %b want 1", level); end
    vectors++; if (edge_cnt !== 2'd1) begin miscompares++; $display("FAIL first_cnt: got %0d want 1", edge_cnt); end
    step();
    vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL rise_one_cycle: got %b want 0", rise); end
  endtask

  task automatic test_full_cycle();
    in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++; if (fall !== (i == 4)) begin miscompares++; $display("FAIL fall[%0d]: got %b want %b", i, fall, (i == 4)); end
      vectors++; if (level !== (i < 4)) begin miscompares++; $display("FAIL fall_level[%0d]: got %b want %b", i, level, (i < 4)); end
      vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL fall_norise[%0d]: got %b want 0", i, rise); end
    end
    vectors++; if (edge_cnt !== 2'd2) begin miscompares++; $display("FAIL fall_cnt: got %0d want 2", edge_cnt); end
    step();
    vectors++; if (fall !== 1'b0) begin miscompares++; $display("FAIL fall_one_cycle: got %b want 0", fall); end
  endtask

  task automatic test_glitch();
    in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy[%0d]: got %b want 1", i, busy); end
    end
    in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle[%0d]: got %b want 0", i, busy); end
      vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL glitch_rise[%0d]: got %b want 0", i, rise); end
      vectors++; if (level !== 1'b0) begin miscompares++; $display("FAIL glitch_level[%0d]: got %b want 0", i, level); end
    end
    vectors++; if (edge_cnt !== 2'd2) begin miscompares++; $display("FAIL glitch_cnt: got %0d want 2", edge_cnt); end
  endtask

  task automatic test_en_drop();
    en = 1'b1; in = 1'b1;
    step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL en_chk_busy: got %b want 1", busy); end
    en = 1'b0;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL en_abort_busy: got %b want 0", busy); end
    vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL en_abort_rise: got %b want 0", rise); end
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++; if (rise !== (i == 4)) begin miscompares++; $display("FAIL requal_rise[%0d]: got %b want %b", i, rise, (i == 4)); end
    end
    vectors++; if (edge_cnt !== 2'd3) begin miscompares++; $display("FAIL requal_cnt: got %0d want 3", edge_cnt); end
    en = 1'b0; in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      vectors++; if (busy !== 1'b0 || fall !== 1'b0 || level !== 1'b1) begin
        miscompares++; $display("FAIL en_freeze[%0d]: got busy=%b fall=%b level=%b want 0 0 1", i, busy, fall, level);
      end
    end
    en = 1'b1; in = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    logic       v;
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    vectors++; if (edge_cnt !== 2'd0) begin miscompares++; $display("FAIL clr_cnt: got %0d want 0", edge_cnt); end
    for (int e = 0; e < 5; e++) begin
      v = (e % 2) != 0;
      hold(v, 4);
      vectors++; if (edge_cnt !== exp_cnt[e]) begin miscompares++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", e, edge_cnt, exp_cnt[e]); end
      vectors++; if (rise !== v || fall !== !v) begin
        miscompares++; $display("FAIL sat_pulse[%0d]: got rise=%b fall=%b want %b %b", e, rise, fall, v, !v);
      end
    end
    hold(1'b1, 3);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    vectors++; if (edge_cnt !== 2'd0) begin miscompares++; $display("FAIL clr_vs_inc_cnt: got %0d want 0", edge_cnt); end
    vectors++; if (rise !== 1'b1 || level !== 1'b1) begin
      miscompares++; $display("FAIL clr_vs_inc_rise: got rise=%b level=%b want 1 1", rise, level);
    end
  endtask

  task automatic test_reset_mid_check();
    hold(1'b0, 4);
    vectors++; if (edge_cnt !== 2'd1) begin miscompares++; $display("FAIL pre_rst_cnt1: got %0d want 1", edge_cnt); end
    hold(1'b1, 4);
    vectors++; if (edge_cnt !== 2'd2) begin miscompares++; $display("FAIL pre_rst_cnt2: got %0d want 2", edge_cnt); end
    hold(1'b0, 3);
    vectors++; if (busy !== 1'b1 || level !== 1'b1) begin
      miscompares++; $display("FAIL pre_rst_chk: got busy=%b level=%b want 1 1", busy, level);
    end
    rstn = 1'b0;
    step();
    vectors++; if (level !== 1'b0) begin miscompares++; $display("FAIL midrst_level: got %b want 0", level); end
    vectors++; if (fall !== 1'b0) begin miscompares++; $display("FAIL midrst_fall: got %b want 0", fall); end
    vectors++; if (edge_cnt !== 2'd0) begin miscompares++; $display("FAIL midrst_cnt: got %0d want 0", edge_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rstn = 1'b1;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL postrst_low_idle: got %b want 0", busy); end
    in = 1'b1;
    step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL postrst_low_state: got %b want 1", busy); end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_glitch();
    test_en_drop();
    test_saturation();
    test_reset_mid_check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
